// File: rtl/truth_table_sweeper_pkg.sv
// truth_table_sweeper_pkg
// Shared definitions for the truth-table sweeper:
//   state_e - sweep controller states, 2-bit encoding
//   rows_f  - number of truth-table rows for a given input count (2**n_in)
package truth_table_sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    function automatic int rows_f(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/tts_settle_counter.sv
// tts_settle_counter
// Loadable up-counter that times how long a stimulus row is held before the
// response is sampled.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   clr_i  - synchronous clear to zero (wins over inc_i)
//   inc_i  - count up by one
//   tc_o   - terminal count: counter currently equals SETTLE-1
module tts_settle_counter
    import truth_table_sweeper_pkg::*;
#(
    parameter int SETTLE = 1,
    localparam int W = $clog2(SETTLE + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == W'(SETTLE - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
// Sweeps every input combination (2**N_IN rows) into N_FN combinational
// functions, holds each row SETTLE cycles, then captures the responses into a
// packed truth-table register tt (bit f*ROWS+r = function f at row r).
// Ports:
//   clk, rst_n         - clock (rising edge), asynchronous active-low reset
//   start, abort       - begin a sweep (IDLE only) / abandon a sweep
//   stim               - row driven to the functions (MSB = x, LSB = z)
//   resp               - function outputs, resp[f] belongs to function f
//   busy               - high while driving/sampling rows
//   row_vld/idx/out    - one-cycle report of each captured row
//   tt                 - captured truth tables
//   done               - one-cycle pulse at the end of a complete sweep
// Optional compare logic, compiled in with TRUTH_TABLE_SWEEPER_CHECK_EN:
//   expect_tt          - golden truth tables ("expect" is a reserved word)
//   mismatch           - sticky per-function mismatch flags
//   first_fail         - first mismatching row (0 if none; qualify by mismatch)
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int N_FN   = 5,
    parameter int SETTLE = 1,
    localparam int ROWS  = rows_f(N_IN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [N_IN-1:0]      stim,
    input  logic [N_FN-1:0]      resp,
    output logic                 busy,
    output logic                 row_vld,
    output logic [N_IN-1:0]      row_idx,
    output logic [N_FN-1:0]      row_out,
    output logic [N_FN*ROWS-1:0] tt,
    output logic                 done
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
    ,
    input  logic [N_FN*ROWS-1:0] expect_tt,
    output logic [N_FN-1:0]      mismatch,
    output logic [N_IN-1:0]      first_fail
`endif
);

    state_e                state_q;
    logic [N_IN-1:0]       stim_q;
    logic [N_IN-1:0]       row_idx_q;
    logic [N_FN-1:0]       row_out_q;
    logic [N_FN*ROWS-1:0]  tt_q;
    logic [N_FN*ROWS-1:0]  tt_d;
    logic                  busy_q;
    logic                  row_vld_q;
    logic                  done_q;

    logic start_ok;     // accepted start: IDLE, start, no abort
    logic capture;      // a row is captured this cycle
    logic abort_run;    // abort outside IDLE
    logic cnt_clr;
    logic cnt_inc;
    logic cnt_tc;

    assign start_ok  = (state_q == IDLE) && start && !abort;
    assign capture   = (state_q == SAMPLE) && !abort;
    assign abort_run = abort && (state_q != IDLE);

    // The counter restarts for every row; SAMPLE clears it so the next DRIVE
    // starts from zero.
    assign cnt_clr = start_ok || (state_q == SAMPLE) || abort_run;
    assign cnt_inc = (state_q == DRIVE) && !abort;

    tts_settle_counter #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .tc_o  (cnt_tc)
    );

    // Next truth table: only the bits of the current row take the response.
    for (genvar gi = 0; gi < N_FN; gi++) begin : g_fn
        for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
            assign tt_d[gi*ROWS+gr] = (stim_q == N_IN'(gr)) ? resp[gi]
                                                            : tt_q[gi*ROWS+gr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            stim_q    <= '0;
            row_idx_q <= '0;
            row_out_q <= '0;
            tt_q      <= '0;
            busy_q    <= 1'b0;
            row_vld_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            row_vld_q <= 1'b0;
            done_q    <= 1'b0;
            if (abort_run) begin
                state_q <= IDLE;
                stim_q  <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_ok) begin
                            tt_q    <= '0;
                            stim_q  <= '0;
                            busy_q  <= 1'b1;
                            state_q <= DRIVE;
                        end
                    end
                    DRIVE: begin
                        if (cnt_tc) begin
                            state_q <= SAMPLE;
                        end
                    end
                    SAMPLE: begin
                        tt_q      <= tt_d;
                        row_vld_q <= 1'b1;
                        row_idx_q <= stim_q;
                        row_out_q <= resp;
                        if (stim_q == N_IN'(ROWS - 1)) begin
                            // Registered so done lines up with the DONE state.
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            stim_q  <= stim_q + 1'b1;
                            state_q <= DRIVE;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign stim    = stim_q;
    assign busy    = busy_q;
    assign row_vld = row_vld_q;
    assign row_idx = row_idx_q;
    assign row_out = row_out_q;
    assign tt      = tt_q;
    assign done    = done_q;

`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
    logic [N_FN-1:0] miss_row;
    logic [N_FN-1:0] mismatch_q;
    logic [N_IN-1:0] first_fail_q;

    for (genvar gi = 0; gi < N_FN; gi++) begin : g_chk
        logic [ROWS-1:0] exp_fn;
        assign exp_fn       = expect_tt[gi*ROWS +: ROWS];
        assign miss_row[gi] = resp[gi] ^ exp_fn[stim_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_q   <= '0;
            first_fail_q <= '0;
        end else if (start_ok) begin
            mismatch_q   <= '0;
            first_fail_q <= '0;
        end else if (capture) begin
            mismatch_q <= mismatch_q | miss_row;
            // Rows are swept in ascending order, so the first row that flags
            // anything while nothing is flagged yet is the first failure.
            if ((mismatch_q == '0) && (miss_row != '0)) begin
                first_fail_q <= stim_q;
            end
        end
    end

    assign mismatch   = mismatch_q;
    assign first_fail = first_fail_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper
// Self-checking bench: a cycle-count model of the sweep predicts every output
// each cycle; directed sweeps pin the model to hand-computed truth tables and
// latencies, then randomized tables, aborts and stray starts exercise the rest.
// A second instance with SETTLE=3 checks that glitches during the settle
// window never reach the captured tables.
module tb_truth_table_sweeper;

    localparam int N_IN = 3;
    localparam int N_FN = 5;
    localparam int ROWS = 8;
    localparam int S    = 1;
    localparam int P    = S + 1;
    localparam int TTW  = N_FN * ROWS;
    localparam logic [TTW-1:0] GOLD_TT  = 40'h44A2458004;
    localparam logic [TTW-1:0] ABORT_TT = 40'h0402050004;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [N_FN-1:0] resp = '0;
    logic [N_IN-1:0] stim;
    logic busy, row_vld, done;
    logic [N_IN-1:0] row_idx;
    logic [N_FN-1:0] row_out;
    logic [TTW-1:0]  tt;

    logic start3 = 1'b0;
    logic glitch3 = 1'b0;
    logic [N_FN-1:0] resp3;
    logic [N_IN-1:0] stim3;
    logic busy3, row_vld3, done3;
    logic [N_IN-1:0] row_idx3;
    logic [N_FN-1:0] row_out3;
    logic [TTW-1:0]  tt3;

`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
    logic [TTW-1:0]  expect_tt = GOLD_TT;
    logic [N_FN-1:0] mismatch, mismatch3;
    logic [N_IN-1:0] first_fail, first_fail3;
`endif

    always #5 clk = ~clk;

    truth_table_sweeper #(.N_IN(N_IN), .N_FN(N_FN), .SETTLE(S)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stim(stim),
        .resp(resp), .busy(busy), .row_vld(row_vld), .row_idx(row_idx),
        .row_out(row_out), .tt(tt), .done(done)
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
        , .expect_tt(expect_tt), .mismatch(mismatch), .first_fail(first_fail)
`endif
    );

    truth_table_sweeper #(.N_IN(N_IN), .N_FN(N_FN), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(1'b0), .stim(stim3),
        .resp(resp3), .busy(busy3), .row_vld(row_vld3), .row_idx(row_idx3),
        .row_out(row_out3), .tt(tt3), .done(done3)
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
        , .expect_tt(GOLD_TT), .mismatch(mismatch3), .first_fail(first_fail3)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // The functions under test, written straight from their boolean definitions.
    function automatic logic [N_FN-1:0] gold_fn(input logic [N_IN-1:0] s);
        logic x, y, z;
        logic [N_FN-1:0] v;
        x = s[2]; y = s[1]; z = s[0];
        v[0] = ~x & y & ~z;
        v[1] = x & y & z;
        v[2] = ~(x & ~y) & ~z;
        v[3] = ~(~x & y) & z;
        v[4] = (~x | y) & ~(~y | z);
        return v;
    endfunction

    // ---------------- behavioural model ----------------
    logic [ROWS-1:0] fn_tbl [N_FN];
    bit              m_active;
    int              m_k;        // cycle number within the current sweep, 1 = first DRIVE
    logic [N_IN-1:0] m_stim;
    logic            m_busy, m_vld, m_done;
    logic [N_IN-1:0] m_idx;
    logic [N_FN-1:0] m_out;
    logic [TTW-1:0]  m_tt;

    function automatic logic [N_FN-1:0] row_resp(input int r);
        logic [N_FN-1:0] v;
        for (int f = 0; f < N_FN; f++) v[f] = fn_tbl[f][r];
        return v;
    endfunction

    task automatic model_reset();
        m_active = 1'b0; m_k = 0; m_stim = '0; m_busy = 1'b0;
        m_vld = 1'b0; m_done = 1'b0; m_idx = '0; m_out = '0; m_tt = '0;
    endtask

    // Each row spans P cycles: S settle cycles then one sampling cycle at k=(r+1)*P.
    task automatic model_edge(input logic s, input logic a);
        int r;
        m_vld  = 1'b0;
        m_done = 1'b0;
        if (!m_active) begin
            if (s && !a) begin
                m_active = 1'b1; m_k = 1; m_tt = '0; m_stim = '0; m_busy = 1'b1;
            end
        end else if (a) begin
            m_active = 1'b0; m_stim = '0; m_busy = 1'b0;
        end else begin
            if (m_k % P == 0) begin
                r = m_k / P - 1;
                for (int f = 0; f < N_FN; f++) m_tt[f*ROWS+r] = fn_tbl[f][r];
                m_vld = 1'b1; m_idx = N_IN'(r); m_out = row_resp(r);
                if (r == ROWS - 1) begin
                    m_done = 1'b1; m_busy = 1'b0;
                end else begin
                    m_stim = N_IN'(r + 1);
                end
            end else if (m_k == ROWS * P + 1) begin
                m_active = 1'b0;
            end
            m_k++;
        end
    endtask

    always @(posedge clk) if (rst_n) model_edge(start, abort);

    // Responses are correct only in sampling cycles; anything else is noise.
    always @(negedge clk) begin
        #1;
        if (m_active && (m_k % P == 0) && (m_k <= ROWS * P)) resp = row_resp(m_k / P - 1);
        else resp = N_FN'($urandom);
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 64'(busy), 64'(m_busy));
            chk("stim", 64'(stim), 64'(m_stim));
            chk("row_vld", 64'(row_vld), 64'(m_vld));
            chk("done", 64'(done), 64'(m_done));
            chk("tt", 64'(tt), 64'(m_tt));
            if (m_vld) begin
                chk("row_idx", 64'(row_idx), 64'(m_idx));
                chk("row_out", 64'(row_out), 64'(m_out));
            end
        end
    end

    assign resp3 = gold_fn(stim3) ^ {N_FN{glitch3}};

    // ---------------- stimulus ----------------
    task automatic step(input logic s, input logic a);
        @(negedge clk);
        #2;
        start = s;
        abort = a;
    endtask

    function automatic logic [TTW-1:0] pack_tbl();
        logic [TTW-1:0] v;
        for (int f = 0; f < N_FN; f++) v[f*ROWS +: ROWS] = fn_tbl[f];
        return v;
    endfunction

    task automatic load_golden();
        logic [N_FN-1:0] v;
        for (int r = 0; r < ROWS; r++) begin
            v = gold_fn(N_IN'(r));
            for (int f = 0; f < N_FN; f++) fn_tbl[f][r] = v[f];
        end
    endtask

    // Start in cycle 0, optionally abort / re-pulse start at given cycles.
    task automatic run_sweep(input int a_at, input int s1, input int s2,
                             output int done_cyc, output int n_done, output int n_vld);
        done_cyc = -1; n_done = 0; n_vld = 0;
        step(1'b1, 1'b0);
        for (int c = 1; c <= ROWS * P + 4; c++) begin
            step((c == s1) || (c == s2), c == a_at);
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (row_vld) n_vld++;
        end
        step(1'b0, 1'b0);
    endtask

    initial begin
        int dc, nd, nv, a_at, s2;
        model_reset();
        load_golden();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        cmp_en = 1'b1;
        chk("reset_tt", 64'(tt), 64'(0));
        chk("reset_stim", 64'(stim), 64'(0));

        // golden sweep: pins the model to the hand-derived tables
        chk("gold_pack", 64'(pack_tbl()), 64'(GOLD_TT));
        run_sweep(-1, -1, -1, dc, nd, nv);
        chk("gold_done_cycle", 64'(dc), 64'(17));
        chk("gold_done_count", 64'(nd), 64'(1));
        chk("gold_vld_count", 64'(nv), 64'(8));
        chk("gold_tt", 64'(tt), 64'(GOLD_TT));
        chk("gold_model_tt", 64'(m_tt), 64'(GOLD_TT));

        // start and abort together in IDLE: stays idle
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("start_abort_idle_busy", 64'(busy), 64'(0));

        // abort during DRIVE of row 5 (cycle 11)
        run_sweep(11, -1, -1, dc, nd, nv);
        chk("abort_done_count", 64'(nd), 64'(0));
        chk("abort_tt", 64'(tt), 64'(ABORT_TT));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_stim", 64'(stim), 64'(0));

        // stray starts mid-sweep and in DONE are ignored
        run_sweep(-1, 5, 17, dc, nd, nv);
        chk("restart_done_cycle", 64'(dc), 64'(17));
        chk("restart_done_count", 64'(nd), 64'(1));
        chk("restart_tt", 64'(tt), 64'(GOLD_TT));
        run_sweep(-1, -1, -1, dc, nd, nv);
        chk("repeat_tt", 64'(tt), 64'(GOLD_TT));
        chk("repeat_done_cycle", 64'(dc), 64'(17));

        // asynchronous reset at row 3
        step(1'b1, 1'b0);
        for (int c = 1; c <= 7; c++) step(1'b0, 1'b0);
        chk("pre_reset_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_tt", 64'(tt), 64'(0));
        chk("async_rst_stim", 64'(stim), 64'(0));
        chk("async_rst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        run_sweep(-1, -1, -1, dc, nd, nv);
        chk("post_reset_tt", 64'(tt), 64'(GOLD_TT));
        chk("post_reset_vld_count", 64'(nv), 64'(8));

`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
        expect_tt = GOLD_TT;
        expect_tt[2*ROWS +: ROWS] = 8'h55;
        run_sweep(-1, -1, -1, dc, nd, nv);
        chk("check_mismatch", 64'(mismatch), 64'(5'b00100));
        chk("check_first_fail", 64'(first_fail), 64'(4));
        expect_tt = GOLD_TT;
        run_sweep(-1, -1, -1, dc, nd, nv);
        chk("check_clean", 64'(mismatch), 64'(0));
        chk("check_clean_ff", 64'(first_fail), 64'(0));
`endif

        // SETTLE=3 instance: wrong response for the first 2 settle cycles of each row
        step(1'b0, 1'b0);
        start3 = 1'b1;
        dc = -1; nd = 0; nv = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            #2;
            start3  = 1'b0;
            glitch3 = (c <= 32) && ((c - 1) % 4 < 2);
            if (done3) begin
                nd++;
                if (dc < 0) dc = c;
            end
            if (row_vld3) nv++;
        end
        glitch3 = 1'b0;
        chk("settle3_done_cycle", 64'(dc), 64'(33));
        chk("settle3_done_count", 64'(nd), 64'(1));
        chk("settle3_vld_count", 64'(nv), 64'(8));
        chk("settle3_tt", 64'(tt3), 64'(GOLD_TT));

        // randomized tables, aborts and stray starts
        repeat (24) begin
            for (int f = 0; f < N_FN; f++) fn_tbl[f] = ROWS'($urandom);
            a_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, ROWS * P)) : -1;
            if (a_at > 1)       s2 = int'($urandom_range(1, a_at - 1));
            else if (a_at < 0)  s2 = int'($urandom_range(1, ROWS * P + 1));
            else                s2 = -1;
            run_sweep(a_at, s2, -1, dc, nd, nv);
            if (a_at < 0) begin
                chk("rand_done_cycle", 64'(dc), 64'(ROWS * P + 1));
                chk("rand_done_count", 64'(nd), 64'(1));
                chk("rand_vld_count", 64'(nv), 64'(ROWS));
                chk("rand_tt", 64'(tt), 64'(pack_tbl()));
            end else begin
                chk("rand_abort_done_count", 64'(nd), 64'(0));
                chk("rand_abort_vld_count", 64'(nv), 64'((a_at - 1) / P));
            end
        end

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Sequential harness that sweeps all 2^N_IN input combinations into N_FN combinational logic functions under test. It captures each function's response into a packed truth-table register and signals completion with a one-cycle done pulse. It is the parametrised successor to the fixed 3-input, 5-function manual truth-table exercises, and replaces hand-written per-row stimulus in benches and on-board self-test.

Parameters:
N_IN, 3, number of function inputs; legal range 1..8; ROWS = 2**N_IN.
N_FN, 5, number of functions evaluated in parallel; legal range 1..16.
SETTLE, 1, cycles stim is held before sampling resp; minimum 1.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
start  in  1  begin sweep; honoured only in IDLE.
abort  in  1  synchronous abort; returns to IDLE with no done pulse.
stim  out  N_IN  input vector driven to the functions; stim[N_IN-1] is the MSB (x), stim[0] is the LSB (z).
resp  in  N_FN  function outputs; resp[f] belongs to function f.
busy  out  1  high in DRIVE and SAMPLE.
row_vld  out  1  one-cycle pulse when a row is captured.
row_idx  out  N_IN  index of the row captured, valid with row_vld.
row_out  out  N_FN  resp value captured, valid with row_vld.
tt  out  N_FN*ROWS  truth tables; bit tt[f*ROWS+r] is function f at row r.
done  out  1  one-cycle pulse at sweep end.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE. stim, row_idx, row_out, tt, the settle counter and all flags are 0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - On start=1: tt<=0, stim<=0, cnt<=0, go to DRIVE.
  - Otherwise hold. tt retains the previous sweep's results indefinitely.
- DRIVE:
  - cnt increments each cycle.
  - When cnt==SETTLE-1, go to SAMPLE. DRIVE therefore lasts exactly SETTLE cycles.
- SAMPLE:
  - Capture tt[f*ROWS+stim]<=resp[f] for all f.
  - Pulse row_vld=1 with row_idx=stim and row_out=resp, registered so they are visible the following cycle.
  - If stim==ROWS-1, go to DONE.
  - Otherwise stim<=stim+1, cnt<=0, go to DRIVE. There is no wrap past ROWS-1.
- DONE: done=1 for exactly one cycle, then go to IDLE. stim holds ROWS-1.
- Latency: with start high in cycle 0, done is high in cycle ROWS*(SETTLE+1)+1. For defaults that is cycle 17.
- busy=1 in DRIVE and SAMPLE only.
- start while busy or in DONE: ignored, with no restart.
- abort has priority over start and over normal transitions in every state except IDLE:
  - Next state is IDLE and stim<=0.
  - tt keeps any rows already captured; rows not yet captured stay 0.
  - No done pulse and no row_vld in that cycle.
- start and abort together in IDLE: abort wins and the block stays in IDLE.
- Reset mid-sweep: immediate return to IDLE, tt cleared.
- resp is sampled only in SAMPLE; resp glitches during DRIVE have no effect.

Optional Feature:
TRUTH_TABLE_SWEEPER_CHECK_EN
- Compiled in, the block adds three ports:
  - expect (in, N_FN*ROWS): golden truth tables, stable for the whole sweep.
  - mismatch (out, N_FN): sticky per-function flag, set in SAMPLE when resp[f]!=expect[f*ROWS+stim], cleared on start and on reset.
  - first_fail (out, N_IN): row index of the first mismatching row in the sweep. It is 0 when there is no mismatch; check mismatch!=0 to tell "no failure" from "failed at row 0".
- Compiled out: these ports do not exist and there is no compare logic.

Decomposition:
- Package truth_table_sweeper_pkg: state enum (IDLE, DRIVE, SAMPLE, DONE), 2-bit encoding, and the ROWS derivation function.
- One sub-module, tts_settle_counter: loadable up-counter with terminal-count output, width $clog2(SETTLE+1).
- FSM, capture and check logic stay in the top module.

Test Plan:
- Defaults; resp[0]=~x&y&~z, resp[1]=x&y&z, resp[2]=~(x&~y)&~z, resp[3]=~(~x&y)&z, resp[4]=(~x|y)&~(~y|z); pulse start -> done at cycle 17, tt per function = 0x04, 0x80, 0x45, 0xA2, 0x44, eight row_vld pulses with row_idx 0..7.
- SETTLE=3; resp driven to the wrong value for the first 2 DRIVE cycles of each row, then correct -> tt matches the golden values; done at cycle 8*4+1=33.
- Abort asserted during DRIVE of row 5 -> IDLE next cycle, no done pulse, tt bits for rows 0..4 retained and rows 5..7 equal 0, busy=0.
- start re-pulsed mid-sweep and in DONE -> ignored, a single done pulse; a subsequent start clears tt and the sweep repeats identically.
- rst_n low for 1 cycle at row 3 -> all outputs 0 asynchronously; a new start sweeps from row 0.
- CHECK_EN, expect for function 2 = 0x55 while actual is 0x45 -> mismatch=5'b00100, first_fail=4; with all expect correct -> mismatch=0.
